dac_sine_writer: RTL and testbench

DAC_SINE_WRITER -- requirements
Module: dac_sine_writer

---
 rtl/sinwave_pkg.sv | 28 ++
 rtl/sine_qrom.sv | 46 ++++
 rtl/dac_sine_writer.sv | 157 +++++++++++++++
 tb/tb_dac_sine_writer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sinwave_pkg.sv
// Shared constants, FSM state encoding and helpers for the sine-wave DAC writer.
package sinwave_pkg;

    localparam int PHASE_MAX = 3600;
    localparam int QUARTER   = 900;
    localparam int OFFS_60   = 600;
    localparam int OFFS_150  = 1500;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_GAP_A  = 3'd3,
        ST_LOAD_B = 3'd4,
        ST_GAP_B  = 3'd5,
        ST_XFER   = 3'd6
    } state_t;

    typedef struct packed {
        logic       neg;
        logic [9:0] addr;
    } qlook_t;

    function automatic int midpoint(input int dw);
        return 1 << (dw - 1);
    endfunction

endpackage

// File: rtl/sine_qrom.sv
// Quarter-wave sine table, 901 entries of DW-1 bits, one registered read port.
module sine_qrom
    import sinwave_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [9:0]    addr,
    output logic [DW-2:0] data
);

    localparam int F = 60;
    localparam logic signed [127:0] PI_FIX = 128'sh3243F6A8885A308D;
    localparam logic signed [127:0] MAXV   = 128'((1 << (DW - 1)) - 1);
    localparam logic signed [127:0] HALF   = 128'sd1 <<< (F - 1);
    // Small bias so the exact 30-degree tie rounds away from zero despite truncation.
    localparam logic signed [127:0] BIAS   = 128'sd1 <<< (F - 20);

    function automatic logic [DW-2:0] qval(input int r);
        logic signed [127:0] x, x2, term, acc, den, scaled;
        x    = (128'(r) * PI_FIX) / 128'sd1800;
        x2   = (x * x) >>> F;
        term = x;
        acc  = x;
        for (int k = 1; k <= 12; k++) begin
            den  = 128'(2 * k * (2 * k + 1));
            term = -((term * x2) >>> F) / den;
            acc  = acc + term;
        end
        scaled = acc * MAXV + HALF + BIAS;
        return scaled[F +: DW-1];
    endfunction

    logic [DW-2:0] table_q [0:QUARTER];

    for (genvar i = 0; i <= QUARTER; i++) begin : g_tab
        localparam logic [DW-2:0] VAL = qval(i);
        assign table_q[i] = VAL;
    end

    always_ff @(posedge clk) begin
        if (en) data <= table_q[addr];
    end

endmodule

// File: rtl/dac_sine_writer.sv
// Converts accepted phase pairs into sine samples and writes them to a dual latched DAC.
// Build option SINWAVE_PHASE_OFFSET_EN adds set60/set150 to derive channel B from channel A.
module dac_sine_writer
    import sinwave_pkg::*;
#(
    parameter int DW     = 12,
    parameter int WR_CYC = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [11:0]   phase_a,
    input  logic [11:0]   phase_b,
    input  logic          phase_valid,
`ifdef SINWAVE_PHASE_OFFSET_EN
    input  logic          set60,
    input  logic          set150,
`endif
    output logic          phase_ready,
    output logic [DW-1:0] dac_a_data,
    output logic [DW-1:0] dac_b_data,
    output logic          dac_a_cs_n,
    output logic          dac_a_wr1_n,
    output logic          dac_b_cs_n,
    output logic          dac_b_wr1_n,
    output logic          dac_xfer_n,
    output logic          dac_wr2_n,
    output logic          dac_ile,
    output logic          done
);

    // state  | meaning
    // IDLE   | waiting for a phase pair; phase_ready high
    // SAMPLE | table reads valid, data outputs registered
    // LOAD_A | channel A input-latch strobe low for WR_CYC cycles
    // GAP_A  | all strobes high, setup/hold margin
    // LOAD_B | channel B input-latch strobe low for WR_CYC cycles
    // GAP_B  | all strobes high, setup/hold margin
    // XFER   | shared transfer strobe low for WR_CYC cycles

    localparam int TW = 4;
    localparam logic [DW-1:0] MID = DW'(midpoint(DW));

    function automatic logic [11:0] wrap_phase(input logic [12:0] p);
        return (p >= 13'(PHASE_MAX)) ? 12'(p - 13'(PHASE_MAX)) : p[11:0];
    endfunction

    function automatic qlook_t quad_lookup(input logic [11:0] p);
        qlook_t q;
        if (p < 12'(QUARTER)) begin
            q.neg  = 1'b0;
            q.addr = 10'(p);
        end else if (p < 12'(2 * QUARTER)) begin
            q.neg  = 1'b0;
            q.addr = 10'(12'(2 * QUARTER) - p);
        end else if (p < 12'(3 * QUARTER)) begin
            q.neg  = 1'b1;
            q.addr = 10'(p - 12'(2 * QUARTER));
        end else begin
            q.neg  = 1'b1;
            q.addr = 10'(12'(PHASE_MAX) - p);
        end
        return q;
    endfunction

    state_t        state, state_nx;
    logic [TW-1:0] tmr;
    logic          accept;
    logic [11:0]   ph_a, ph_b;
    qlook_t        look_a, look_b;
    logic          neg_a, neg_b;
    logic [DW-2:0] rom_a, rom_b;
    logic          a_strb_n, b_strb_n, x_strb_n;

    assign phase_ready = (state == ST_IDLE) && dac_ile;
    assign accept      = phase_valid && phase_ready;
    assign ph_a        = wrap_phase(13'(phase_a));

`ifdef SINWAVE_PHASE_OFFSET_EN
    always_comb begin
        ph_b = wrap_phase(13'(phase_b));
        if (set60)
            ph_b = wrap_phase(13'(ph_a) + 13'(OFFS_60));
        else if (set150)
            ph_b = wrap_phase(13'(ph_a) + 13'(OFFS_150));
    end
`else
    assign ph_b = wrap_phase(13'(phase_b));
`endif

    assign look_a = quad_lookup(ph_a);
    assign look_b = quad_lookup(ph_b);

    sine_qrom #(.DW(DW)) u_rom_a (.clk(clk), .en(accept), .addr(look_a.addr), .data(rom_a));
    sine_qrom #(.DW(DW)) u_rom_b (.clk(clk), .en(accept), .addr(look_b.addr), .data(rom_b));

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept) state_nx = ST_SAMPLE;
            ST_SAMPLE: state_nx = ST_LOAD_A;
            ST_LOAD_A: if (tmr == '0) state_nx = ST_GAP_A;
            ST_GAP_A:  state_nx = ST_LOAD_B;
            ST_LOAD_B: if (tmr == '0) state_nx = ST_GAP_B;
            ST_GAP_B:  state_nx = ST_XFER;
            ST_XFER:   if (tmr == '0) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free yet aligned with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            done     <= 1'b0;
            dac_ile  <= 1'b0;
            a_strb_n <= 1'b1;
            b_strb_n <= 1'b1;
            x_strb_n <= 1'b1;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
        end else begin
            state    <= state_nx;
            dac_ile  <= 1'b1;
            done     <= (state == ST_XFER) && (state_nx == ST_IDLE);
            a_strb_n <= (state_nx != ST_LOAD_A);
            b_strb_n <= (state_nx != ST_LOAD_B);
            x_strb_n <= (state_nx != ST_XFER);
            if (state_nx != state)
                tmr <= TW'(WR_CYC - 1);
            else if (tmr != '0)
                tmr <= tmr - TW'(1);
            if (accept) begin
                neg_a <= look_a.neg;
                neg_b <= look_b.neg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dac_a_data <= MID;
            dac_b_data <= MID;
        end else if (state == ST_SAMPLE) begin
            dac_a_data <= neg_a ? MID - DW'(rom_a) : MID + DW'(rom_a);
            dac_b_data <= neg_b ? MID - DW'(rom_b) : MID + DW'(rom_b);
        end
    end

    assign dac_a_cs_n  = a_strb_n;
    assign dac_a_wr1_n = a_strb_n;
    assign dac_b_cs_n  = b_strb_n;
    assign dac_b_wr1_n = b_strb_n;
    assign dac_xfer_n  = x_strb_n;
    assign dac_wr2_n   = x_strb_n;

endmodule

// File: tb/tb_dac_sine_writer.sv
// Directed and randomized checks of dac_sine_writer against a floating-point sine model.
module tb_dac_sine_writer;

    localparam int  DW     = 12;
    localparam int  WR_CYC = 4;
    localparam int  MID    = 2048;
    localparam int  MAXV   = 2047;
    localparam real PI     = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          reset;
    logic [11:0]   phase_a, phase_b;
    logic          phase_valid;
    logic          set60, set150;
    logic          phase_ready;
    logic [DW-1:0] dac_a_data, dac_b_data;
    logic          dac_a_cs_n, dac_a_wr1_n, dac_b_cs_n, dac_b_wr1_n;
    logic          dac_xfer_n, dac_wr2_n, dac_ile, done;

    dac_sine_writer #(.DW(DW), .WR_CYC(WR_CYC)) dut (
        .clk(clk), .reset(reset),
        .phase_a(phase_a), .phase_b(phase_b), .phase_valid(phase_valid),
`ifdef SINWAVE_PHASE_OFFSET_EN
        .set60(set60), .set150(set150),
`endif
        .phase_ready(phase_ready),
        .dac_a_data(dac_a_data), .dac_b_data(dac_b_data),
        .dac_a_cs_n(dac_a_cs_n), .dac_a_wr1_n(dac_a_wr1_n),
        .dac_b_cs_n(dac_b_cs_n), .dac_b_wr1_n(dac_b_wr1_n),
        .dac_xfer_n(dac_xfer_n), .dac_wr2_n(dac_wr2_n),
        .dac_ile(dac_ile), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Accept and done history, taken from pre-edge values at each rising edge.
    int pcyc = 0;
    int acc_q[$];
    int done_q[$];

    always @(posedge clk) begin
        pcyc = pcyc + 1;
        if (phase_valid && phase_ready) acc_q.push_back(pcyc);
        if (done) done_q.push_back(pcyc - 1);
    end

    int a_low = 0, b_low = 0, x_low = 0;
    int stable_err = 0, excl_err = 0, pair_err = 0;
    logic [DW-1:0] prev_a = '0, prev_b = '0;
    bit prev_low = 1'b0;

    always @(negedge clk) begin
        bit lo_a, lo_b, lo_x;
        lo_a = !dac_a_cs_n;
        lo_b = !dac_b_cs_n;
        lo_x = !dac_xfer_n;
        if (dac_a_cs_n != dac_a_wr1_n || dac_b_cs_n != dac_b_wr1_n || dac_xfer_n != dac_wr2_n)
            pair_err++;
        if (int'(lo_a) + int'(lo_b) + int'(lo_x) > 1) excl_err++;
        if ((lo_a || lo_b || lo_x) && prev_low && (dac_a_data != prev_a || dac_b_data != prev_b))
            stable_err++;
        a_low += int'(lo_a);
        b_low += int'(lo_b);
        x_low += int'(lo_x);
        prev_low = lo_a || lo_b || lo_x;
        prev_a   = dac_a_data;
        prev_b   = dac_b_data;
    end

    // Ideal sample straight from the sine definition, rounding half away from zero.
    function automatic int model(input int ph);
        int  p, mag;
        real s;
        p = (ph >= 3600) ? ph - 3600 : ph;
        s = real'(MAXV) * $sin(real'(p) * PI / 1800.0);
        if (s >= 0.0) mag = int'($floor(s + 0.5 + 1.0e-6));
        else          mag = -int'($floor(-s + 0.5 + 1.0e-6));
        return MID + mag;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!phase_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!phase_ready) check("ready_timeout", int'(phase_ready), 1);
    endtask

    task automatic update(input int pa, input int pb, input int phb, input string tag);
        int n0, a0, b0, x0, n;
        wait_ready();
        n0 = acc_q.size();
        a0 = a_low; b0 = b_low; x0 = x_low;
        #1;
        phase_a = 12'(pa);
        phase_b = 12'(pb);
        phase_valid = 1'b1;
        @(negedge clk);
        #1 phase_valid = 1'b0;
        check({tag, "_accept"}, acc_q.size() - n0, 1);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 3 * WR_CYC + 3);
        check({tag, "_ready_at_done"}, int'(phase_ready), 1);
        check({tag, "_a_data"}, int'(dac_a_data), model(pa));
        check({tag, "_b_data"}, int'(dac_b_data), model(phb));
        check({tag, "_a_low"}, a_low - a0, WR_CYC);
        check({tag, "_b_low"}, b_low - b0, WR_CYC);
        check({tag, "_x_low"}, x_low - x0, WR_CYC);
        @(negedge clk);
        check({tag, "_done_width"}, int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int pa[4], pb[4];
        int n, n0, x0, d0, ra, rb;

        reset = 1'b0;
        phase_a = '0;
        phase_b = '0;
        phase_valid = 1'b0;
        set60 = 1'b0;
        set150 = 1'b0;

        @(negedge clk);
        check("rst_strobes", int'({dac_a_cs_n, dac_a_wr1_n, dac_b_cs_n, dac_b_wr1_n, dac_xfer_n, dac_wr2_n}), 63);
        check("rst_ile", int'(dac_ile), 0);
        check("rst_ready", int'(phase_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_a_data", int'(dac_a_data), MID);
        check("rst_b_data", int'(dac_b_data), MID);

        #2 reset = 1'b1;
        #1;
        check("rel_ready_before_edge", int'(phase_ready), 0);
        @(negedge clk);
        check("rel_ile", int'(dac_ile), 1);
        check("rel_ready", int'(phase_ready), 1);

        update(0, 900, 900, "q0_q1");
        check("q0_a_const", int'(dac_a_data), 2048);
        check("q1_b_const", int'(dac_b_data), 4095);

        update(2700, 3599, 3599, "q3");
        check("q3_a_const", int'(dac_a_data), 1);
        check("q3_b_const", int'(dac_b_data), 2044);

        update(4095, 1800, 1800, "wrap");
        check("wrap_a_495", int'(dac_a_data), model(495));

        for (int i = 0; i < 6; i++) begin
            ra = int'($urandom_range(0, 4095));
            rb = int'($urandom_range(0, 4095));
            update(ra, rb, rb, "rand");
        end

`ifdef SINWAVE_PHASE_OFFSET_EN
        set60 = 1'b1;
        set150 = 1'b1;
        update(0, 1234, 600, "off60");
        check("off60_b_const", int'(dac_b_data), 3821);
        set60 = 1'b0;
        update(3000, 77, 900, "off150");
        check("off150_b_const", int'(dac_b_data), 4095);
        set150 = 1'b0;
        ra = int'($urandom_range(0, 4095));
        set60 = 1'b1;
        update(ra, 5, (ra + 600) % 3600, "off60_rand");
        set60 = 1'b0;
`endif

        // Back-to-back with valid held high; inputs change while busy and must be ignored.
        for (int i = 0; i < 4; i++) begin
            pa[i] = int'($urandom_range(0, 3599));
            pb[i] = int'($urandom_range(0, 3599));
        end
        wait_ready();
        n0 = acc_q.size();
        #1;
        phase_a = 12'(pa[0]);
        phase_b = 12'(pb[0]);
        phase_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (acc_q.size() < n0 + i + 1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("b2b_accept", acc_q.size(), n0 + i + 1);
            #1;
            if (i < 2) begin
                phase_a = 12'(pa[i + 1]);
                phase_b = 12'(pb[i + 1]);
            end else begin
                phase_valid = 1'b0;
            end
            n = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done", int'(done), 1);
            check("b2b_a_data", int'(dac_a_data), model(pa[i]));
            check("b2b_b_data", int'(dac_b_data), model(pb[i]));
        end
        repeat (20) @(negedge clk);
        check("b2b_accept_total", acc_q.size() - n0, 3);
        if (acc_q.size() >= n0 + 3) begin
            check("b2b_gap1", acc_q[n0 + 1] - acc_q[n0], 16);
            check("b2b_gap2", acc_q[n0 + 2] - acc_q[n0 + 1], 16);
        end
        check("accept_done_count", done_q.size(), acc_q.size());

        // Reset during the second LOAD_B cycle.
        wait_ready();
        #1;
        phase_a = 12'd450;
        phase_b = 12'd1350;
        phase_valid = 1'b1;
        @(negedge clk);
        #1 phase_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_b_cs_low", int'(dac_b_cs_n), 0);
        check("mid_a_data", int'(dac_a_data), model(450));
        x0 = x_low;
        d0 = done_q.size();
        #2 reset = 1'b0;
        #1;
        check("async_strobes", int'({dac_a_cs_n, dac_a_wr1_n, dac_b_cs_n, dac_b_wr1_n, dac_xfer_n, dac_wr2_n}), 63);
        check("async_a_data", int'(dac_a_data), MID);
        check("async_b_data", int'(dac_b_data), MID);
        check("async_ile", int'(dac_ile), 0);
        check("async_ready", int'(phase_ready), 0);
        check("async_done", int'(done), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", int'(phase_ready), 1);
        check("post_rst_ile", int'(dac_ile), 1);
        repeat (20) @(negedge clk);
        check("post_rst_no_xfer", x_low - x0, 0);
        check("post_rst_no_done", done_q.size() - d0, 0);

        update(1350, 450, 450, "after_rst");

        check("strobe_pairs", pair_err, 0);
        check("strobe_exclusive", excl_err, 0);
        check("data_stable", stable_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
